// File: rtl/nf_rule_packer_pkg.sv
// Shared rule types and constants for the NF rule packer.
// Defines rule_nf_t, the rule width constants and the default pack factor.
package nf_rule_packer_pkg;

  localparam int unsigned RULE_NF_DATA_WIDTH = 16;

  typedef struct packed {
    logic [RULE_NF_DATA_WIDTH-1:0] data;
    logic                          last;
  } rule_nf_t;

  localparam int unsigned RULE_NF_WIDTH = $bits(rule_nf_t);
  localparam int unsigned NF_PACK_N     = 8;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } pack_state_t;

endpackage

// File: rtl/nf_rule_packer.sv
// Packs a stream of rules into PACK_N-slot output beats; a last rule closes the packet.
// Optional statistics counters are enabled with the NF_PACKER_STATS_EN macro.
module nf_rule_packer
  import nf_rule_packer_pkg::*;
#(
  parameter int unsigned PACK_N = NF_PACK_N
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [RULE_NF_WIDTH-1:0]             in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [PACK_N*RULE_NF_DATA_WIDTH-1:0] out_data,
  output logic [$clog2(PACK_N+1)-1:0]          out_cnt,
  output logic                                 out_last,
  output logic                                 out_valid,
  input  logic                                 out_ready
`ifdef NF_PACKER_STATS_EN
  ,
  output logic [31:0]                          stat_pkt,
  output logic [31:0]                          stat_rule
`endif
);

  localparam int unsigned CW = $clog2(PACK_N + 1);

  pack_state_t state, state_next;
  rule_nf_t    rule;
  logic [PACK_N-1:0][RULE_NF_DATA_WIDTH-1:0] slots;
  logic [CW-1:0] slot_cnt;
  logic          last_q;
  logic          accept;
  logic          emit_done;

  assign rule      = rule_nf_t'(in_data);
  assign accept    = (state == FILL) && in_valid;
  assign emit_done = (state == EMIT) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        // A last rule or the write that fills the final slot closes the beat.
        if (in_valid && (rule.last || slot_cnt == CW'(PACK_N - 1)))
          state_next = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots    <= '0;
      slot_cnt <= '0;
      last_q   <= 1'b0;
    end else if (accept) begin
      if (rule.last) begin
        last_q <= 1'b1;
      end else begin
        for (int unsigned i = 0; i < PACK_N; i++)
          if (slot_cnt == CW'(i)) slots[i] <= rule.data;
        slot_cnt <= slot_cnt + CW'(1);
      end
    end else if (emit_done) begin
      slots    <= '0;
      slot_cnt <= '0;
      last_q   <= 1'b0;
    end
  end

  // Slots beyond slot_cnt are always zero because they are cleared after each beat.
  assign out_data = (state == EMIT) ? slots : '0;
  assign out_cnt  = (state == EMIT) ? slot_cnt : '0;
  assign out_last = (state == EMIT) && last_q;

`ifdef NF_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt  <= '0;
      stat_rule <= '0;
    end else begin
      if (emit_done && last_q)   stat_pkt  <= stat_pkt + 32'd1;
      if (accept && !rule.last)  stat_rule <= stat_rule + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nf_rule_packer.sv
// Directed bench for nf_rule_packer with a queue-based scoreboard of expected beats.
// Statistics checks compile in when NF_PACKER_STATS_EN is defined.
module tb_nf_rule_packer;
  import nf_rule_packer_pkg::*;

  localparam int unsigned PN = 8;
  localparam int unsigned DW = RULE_NF_DATA_WIDTH;
  localparam int unsigned OW = PN * DW;

  typedef struct {
    logic [OW-1:0] data;
    logic [3:0]    cnt;
    logic          last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [RULE_NF_WIDTH-1:0] in_data = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [OW-1:0]            out_data;
  logic [3:0]               out_cnt;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
`ifdef NF_PACKER_STATS_EN
  logic [31:0] stat_pkt, stat_rule;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned beats = 0;
  beat_t       exp_q[$];
  logic [DW-1:0] m_slots[PN];
  int unsigned   m_cnt = 0;

  nf_rule_packer #(.PACK_N(PN)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef NF_PACKER_STATS_EN
    , .stat_pkt(stat_pkt), .stat_rule(stat_rule)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_emit(input logic l);
    beat_t b;
    b.data = '0;
    for (int unsigned i = 0; i < m_cnt; i++) b.data[i*DW +: DW] = m_slots[i];
    b.cnt  = 4'(m_cnt);
    b.last = l;
    exp_q.push_back(b);
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [DW-1:0] d, input logic l);
    if (l) model_emit(1'b1);
    else begin
      m_slots[m_cnt] = d;
      m_cnt++;
      if (m_cnt == PN) model_emit(1'b0);
    end
  endtask

  // Drive one rule; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1;
    in_data  = {d, l};
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
    end else begin
      model_push(d, l);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", OW'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_data", out_data, b.data);
        chk("beat_cnt", OW'(out_cnt), OW'(b.cnt));
        chk("beat_last", OW'(out_last), OW'(b.last));
      end
    end
  end

  initial begin
    beat_t hb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // reset state
    chk("rst_valid", OW'(out_valid), 0);
    chk("rst_cnt", OW'(out_cnt), 0);
    chk("rst_last", OW'(out_last), 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", OW'(in_ready), 1);

    // three rules then last; valid one cycle after accepting edge
    send(16'h0011, 0); send(16'h0022, 0); send(16'h0033, 0); send(16'h0000, 1);
    chk("latency_valid", OW'(out_valid), 1);
    drain();

    // full beat then last-only beat
    for (int unsigned i = 1; i <= 8; i++) send(16'(i), 0);
    send(16'hFFFF, 1);
    drain();

    // empty packet
    send(16'hABCD, 1);
    drain();

    // backpressure for 10 cycles in EMIT
    out_ready = 1'b0;
    send(16'h00A1, 0); send(16'h00A2, 0); send(16'h00A3, 0); send(16'h0000, 1);
    hb = exp_q[0];
    in_valid = 1'b1;
    in_data  = {16'h00B1, 1'b0};
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_valid", OW'(out_valid), 1);
      chk("hold_ready", OW'(in_ready), 0);
      chk("hold_data", out_data, hb.data);
      chk("hold_cnt", OW'(out_cnt), OW'(hb.cnt));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(16'h00B1, 0); send(16'h0000, 1);
    drain();

    // reset mid-packet after 5 rules
    for (int unsigned i = 0; i < 5; i++) send(16'h0100 + 16'(i), 0);
    pulse_rst();
    chk("midrst_valid", OW'(out_valid), 0);
    chk("midrst_ready", OW'(in_ready), 1);
    send(16'h0C01, 0); send(16'h0C02, 0); send(16'h0000, 1);
    drain();

    // reset while a beat is pending in EMIT
    out_ready = 1'b0;
    send(16'h0D01, 0); send(16'h0000, 1);
    @(negedge clk);
    chk("pend_valid", OW'(out_valid), 1);
    pulse_rst();
    out_ready = 1'b1;
    chk("emitrst_valid", OW'(out_valid), 0);
    chk("emitrst_ready", OW'(in_ready), 1);
    send(16'h0E01, 0); send(16'h0000, 1);
    drain();

`ifdef NF_PACKER_STATS_EN
    pulse_rst();
    chk("stat_pkt_rst", OW'(stat_pkt), 0);
    chk("stat_rule_rst", OW'(stat_rule), 0);
    for (int unsigned i = 0; i < 4; i++) send(16'h2000 + 16'(i), 0);
    send(16'h0000, 1);
    send(16'h0000, 1);
    for (int unsigned i = 0; i < 9; i++) send(16'h3000 + 16'(i), 0);
    send(16'h0000, 1);
    drain();
    chk("stat_pkt", OW'(stat_pkt), 3);
    chk("stat_rule", OW'(stat_rule), 13);
`endif

    chk("beats_seen_nonzero", OW'(beats != 0), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
